ili9341_init_seq: RTL and testbench

ILI9341_INIT_SEQ -- requirements
Module: ili9341_init_seq

---
 rtl/ili9341_pkg.sv | 44 ++++
 rtl/ili9341_init_seq.sv | 145 ++++++++++++++
 tb/tb_ili9341_init_seq.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// ili9341_pkg: shared definitions for the ILI9341 init sequencer.
// Holds the FSM state enum, the command-ROM word layout, the end-marker
// constant and the command codes that need a post-command settle delay.
// The WAIT state exists only when ILI9341_INIT_DELAY_EN is defined.
package ili9341_pkg;

  // Command-ROM word: [9] reserved, [8] dc (0 = command, 1 = parameter), [7:0] byte
  localparam int unsigned ROM_W    = 10;
  localparam int unsigned RSVD_BIT = 9;
  localparam int unsigned DC_BIT   = 8;
  localparam int unsigned BYTE_MSB = 7;
  localparam int unsigned BYTE_LSB = 0;

  localparam logic [7:0] END_MARKER = 8'hFF;
  localparam logic [7:0] CMD_SLPOUT = 8'h11;
  localparam logic [7:0] CMD_DISPON = 8'h29;

  typedef struct packed {
    logic       rsvd;
    logic       dc;
    logic [7:0] data;
  } rom_word_t;

`ifdef ILI9341_INIT_DELAY_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, WAIT, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, SEND, DONE
  } state_t;
`endif

  // A command word of 0xFF terminates the ROM program
  function automatic logic is_end_marker(input rom_word_t w);
    return (w.dc == 1'b0) && (w.data == END_MARKER);
  endfunction

  // Sleep-out and display-on need the panel to settle before the next byte
  function automatic logic is_delay_cmd(input logic dc, input logic [7:0] b);
    return (dc == 1'b0) && ((b == CMD_SLPOUT) || (b == CMD_DISPON));
  endfunction

endpackage

// File: rtl/ili9341_init_seq.sv
// ili9341_init_seq: walks a command ROM and hands each byte to an SPI
// transmitter over a valid/ready handshake, stopping at the end marker
// (command 0xFF) or at the last ROM address.
// Optional: define ILI9341_INIT_DELAY_EN to insert a DELAY_CYCLES wait after
// the sleep-out (0x11) and display-on (0x29) commands.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, starts the sequence (ignored while busy)
//   rom_addr/rom_data   ROM read port, one-cycle read latency
//   spi_valid/spi_ready byte handshake; spi_dc, spi_data carry the byte
//   busy, done          busy while running; done sticky until reset or start
module ili9341_init_seq
  import ili9341_pkg::*;
#(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DELAY_CYCLES = 15_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              spi_valid,
  input  logic              spi_ready,
  output logic              spi_dc,
  output logic [7:0]        spi_data,
  output logic              busy,
  output logic              done
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              valid_nxt, dc_nxt, busy_nxt, done_nxt;
  logic [7:0]        data_nxt;
  rom_word_t         word;
  logic              rsvd_unused;

  assign word        = rom_word_t'(rom_data);
  assign rsvd_unused = word.rsvd;

`ifdef ILI9341_INIT_DELAY_EN
  localparam int unsigned CNT_W = (DELAY_CYCLES > 2) ? $clog2(DELAY_CYCLES) : 1;
  logic [CNT_W-1:0] delay_cnt, delay_cnt_nxt;
`else
  localparam int unsigned delay_cycles_unused = DELAY_CYCLES;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rom_addr  <= '0;
      spi_valid <= 1'b0;
      spi_dc    <= 1'b0;
      spi_data  <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ILI9341_INIT_DELAY_EN
      delay_cnt <= '0;
`endif
    end else begin
      state     <= state_nxt;
      rom_addr  <= addr_nxt;
      spi_valid <= valid_nxt;
      spi_dc    <= dc_nxt;
      spi_data  <= data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef ILI9341_INIT_DELAY_EN
      delay_cnt <= delay_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    valid_nxt = spi_valid;
    dc_nxt    = spi_dc;
    data_nxt  = spi_data;
    busy_nxt  = busy;
    done_nxt  = done;
`ifdef ILI9341_INIT_DELAY_EN
    delay_cnt_nxt = delay_cnt;
`endif
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
          done_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      // Address is presented here; the ROM word appears next cycle
      FETCH: state_nxt = LOAD;
      LOAD: begin
        if (is_end_marker(word)) begin
          state_nxt = DONE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = SEND;
          valid_nxt = 1'b1;
          dc_nxt    = word.dc;
          data_nxt  = word.data;
        end
      end
      SEND: begin
        if (spi_ready) begin
          valid_nxt = 1'b0;
          // Last ROM entry consumed without a marker: stop rather than wrap
          if (rom_addr == {ADDR_W{1'b1}}) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            addr_nxt  = rom_addr + ADDR_W'(1);
            state_nxt = FETCH;
`ifdef ILI9341_INIT_DELAY_EN
            if (is_delay_cmd(spi_dc, spi_data)) begin
              state_nxt     = WAIT;
              delay_cnt_nxt = '0;
            end
`endif
          end
        end
      end
`ifdef ILI9341_INIT_DELAY_EN
      // Occupies exactly DELAY_CYCLES cycles
      WAIT: begin
        if (delay_cnt == CNT_W'(DELAY_CYCLES - 1)) begin
          state_nxt = FETCH;
        end else begin
          delay_cnt_nxt = delay_cnt + CNT_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ili9341_init_seq.sv
// tb_ili9341_init_seq: randomized self-checking bench for ili9341_init_seq.
// Two instances: a 64-entry ROM (ADDR_W=6) and a 4-entry ROM (ADDR_W=2),
// both with DELAY_CYCLES=20. The reference model derives the expected byte
// stream straight from ROM contents.
module tb_ili9341_init_seq;

  localparam int unsigned DLY = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       spi_ready;
  logic [5:0] addr_a;
  logic [1:0] addr_b;
  logic [9:0] rom_data_a, rom_data_b;
  logic       valid_a, dc_a, busy_a, done_a;
  logic       valid_b, dc_b, busy_b, done_b;
  logic [7:0] data_a, data_b;

  always #5 clk = ~clk;

  ili9341_init_seq #(.ADDR_W(6), .DELAY_CYCLES(DLY)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .rom_addr(addr_a), .rom_data(rom_data_a),
    .spi_valid(valid_a), .spi_ready(spi_ready), .spi_dc(dc_a), .spi_data(data_a),
    .busy(busy_a), .done(done_a));

  ili9341_init_seq #(.ADDR_W(2), .DELAY_CYCLES(DLY)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .rom_addr(addr_b), .rom_data(rom_data_b),
    .spi_valid(valid_b), .spi_ready(spi_ready), .spi_dc(dc_b), .spi_data(data_b),
    .busy(busy_b), .done(done_b));

  // One-cycle-latency ROMs
  logic [9:0] rom_a [64];
  logic [9:0] rom_b [4];
  always @(posedge clk) begin
    rom_data_a <= rom_a[addr_a];
    rom_data_b <= rom_b[addr_b];
  end

  // spi_ready driver
  bit force_low = 1'b0, rand_ready = 1'b0;
  always @(negedge clk)
    spi_ready = force_low ? 1'b0 : (rand_ready ? (($urandom % 3) != 0) : 1'b1);

  // Handshake recorder and protocol watcher
  int         cyc = 0;
  logic [8:0] hs_a[$], hs_b[$];
  int         hs_cyc_a[$];
  int         done_cyc_a = 0;
  int         viol_a = 0;
  bit         stall_a = 1'b0, done_prev_a = 1'b0;
  logic [8:0] stall_word_a = '0;
  bit         b_left0 = 1'b0, b_wrapped = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (stall_a && (!valid_a || {dc_a, data_a} != stall_word_a)) viol_a++;
      if (valid_a && spi_ready) begin
        hs_a.push_back({dc_a, data_a});
        hs_cyc_a.push_back(cyc);
      end
      stall_a      = valid_a && !spi_ready;
      stall_word_a = {dc_a, data_a};
      if (done_a && !done_prev_a) done_cyc_a = cyc;
      done_prev_a = done_a;
      if (valid_b && spi_ready) hs_b.push_back({dc_b, data_b});
      if (addr_b != 2'd0) b_left0 = 1'b1;
      else if (b_left0) b_wrapped = 1'b1;
    end else begin
      stall_a     = 1'b0;
      done_prev_a = 1'b0;
    end
    cyc++;
  end

  int         nvec = 0, nerr = 0;
  logic [8:0] exp_q[$];
  int         exp_addr;

  // Expected stream: entries in order up to (not including) the end marker
  task automatic model_a();
    exp_q.delete();
    exp_addr = 63;
    for (int i = 0; i < 64; i++) begin
      if (rom_a[i][8] == 1'b0 && rom_a[i][7:0] == 8'hFF) begin
        exp_addr = i;
        break;
      end
      exp_q.push_back(rom_a[i][8:0]);
    end
  endtask

  task automatic model_b();
    exp_q.delete();
    exp_addr = 3;
    for (int i = 0; i < 4; i++) begin
      if (rom_b[i][8] == 1'b0 && rom_b[i][7:0] == 8'hFF) begin
        exp_addr = i;
        break;
      end
      exp_q.push_back(rom_b[i][8:0]);
    end
  endtask

  // -1 when equal, -2 on length mismatch, else first differing index
  function automatic int seq_diff(input logic [8:0] got[$], input logic [8:0] want[$]);
    if (got.size() != want.size()) return -2;
    foreach (want[i]) if (got[i] !== want[i]) return i;
    return -1;
  endfunction

  task automatic load_rom_a(input logic [9:0] w[$]);
    for (int i = 0; i < 64; i++) rom_a[i] = 10'($urandom);
    foreach (w[i]) rom_a[i] = w[i];
  endtask

  task automatic clear_rec();
    hs_a.delete();
    hs_cyc_a.delete();
    hs_b.delete();
    viol_a = 0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, output bit ok);
    int n = 0;
    while (!done_a && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = done_a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({addr_a, valid_a, dc_a, data_a, busy_a, done_a} !== 18'd0) begin
      nerr++;
      $display("FAIL reset_a: addr=%0d valid=%b dc=%b data=%h busy=%b done=%b, all required 0",
               addr_a, valid_a, dc_a, data_a, busy_a, done_a);
    end
    nvec++;
    if ({addr_b, valid_b, dc_b, data_b, busy_b, done_b} !== 14'd0) begin
      nerr++;
      $display("FAIL reset_b: addr=%0d valid=%b dc=%b data=%h busy=%b done=%b, all required 0",
               addr_b, valid_b, dc_b, data_b, busy_b, done_b);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    nvec++;
    if ({valid_a, busy_a, done_a, addr_a} !== 9'd0) begin
      nerr++;
      $display("FAIL idle_no_start: valid=%b busy=%b done=%b addr=%0d, required all 0",
               valid_a, busy_a, done_a, addr_a);
    end
  endtask

  task automatic test_basic();
    logic [9:0] w[$] = '{10'h0CB, 10'h139, 10'h0FF};
    bit ok;
    int d;
    force_low = 1'b0; rand_ready = 1'b0;
    load_rom_a(w); model_a(); clear_rec();
    pulse_start_a();
    wait_done_a(200, ok);
    nvec++;
    if (!ok) begin nerr++; $display("FAIL basic_done: done=%b required 1 within 200 cycles", done_a); end
    d = seq_diff(hs_a, exp_q);
    nvec++;
    if (d !== -1) begin nerr++; $display("FAIL basic_seq: %0d handshakes (diff code %0d), required 2: 0CB,139", hs_a.size(), d); end
    nvec++;
    if ({done_a, busy_a, valid_a, addr_a} !== {1'b1, 1'b0, 1'b0, 6'(exp_addr)}) begin
      nerr++;
      $display("FAIL basic_end: done=%b busy=%b valid=%b addr=%0d, required 1 0 0 %0d", done_a, busy_a, valid_a, addr_a, exp_addr);
    end
    nvec++;
    if (hs_cyc_a.size() == 2 && (hs_cyc_a[1] - hs_cyc_a[0]) > 4) begin
      nerr++;
      $display("FAIL basic_rate: handshake spacing %0d cycles, required at most 4", hs_cyc_a[1] - hs_cyc_a[0]);
    end
  endtask

  task automatic test_stall();
    logic [9:0] w[$] = '{10'h02A, 10'h100, 10'h0FF};
    bit ok;
    int n = 0, bad = 0, d;
    force_low = 1'b1; rand_ready = 1'b0;
    load_rom_a(w); model_a(); clear_rec();
    pulse_start_a();
    while (!valid_a && n < 20) begin @(negedge clk); n++; end
    nvec++;
    if (!valid_a) begin nerr++; $display("FAIL stall_valid: valid=%b required 1 within 20 cycles", valid_a); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!valid_a || {dc_a, data_a} !== 9'h02A) bad++;
    end
    nvec++;
    if (bad !== 0) begin nerr++; $display("FAIL stall_hold: %0d unstable cycles, required 0", bad); end
    nvec++;
    if (hs_a.size() !== 0) begin nerr++; $display("FAIL stall_nohs: %0d handshakes while not ready, required 0", hs_a.size()); end
    force_low = 1'b0;
    wait_done_a(200, ok);
    d = seq_diff(hs_a, exp_q);
    nvec++;
    if (!ok || d !== -1 || viol_a !== 0) begin
      nerr++;
      $display("FAIL stall_seq: done=%b handshakes=%0d diff=%0d violations=%0d, required 1 2 -1 0", ok, hs_a.size(), d, viol_a);
    end
  endtask

  task automatic test_random(input int iters);
    force_low = 1'b0; rand_ready = 1'b1;
    for (int it = 0; it < iters; it++) begin
      logic [9:0] w[$];
      bit ok;
      int d, len;
      len = 1 + int'($urandom % 10);
      for (int i = 0; i < len; i++) begin
        logic [9:0] e;
        e = 10'($urandom);
        if (e[8] == 1'b0 && e[7:0] == 8'hFF) e[7:0] = 8'hFE;
        w.push_back(e);
      end
      w.push_back({1'($urandom), 1'b0, 8'hFF});
      load_rom_a(w); model_a(); clear_rec();
      pulse_start_a();
      wait_done_a(3000, ok);
      d = seq_diff(hs_a, exp_q);
      nvec++;
      if (!ok || d !== -1) begin
        nerr++;
        $display("FAIL random_seq[%0d]: done=%b got %0d bytes diff=%0d, required %0d bytes", it, ok, hs_a.size(), d, exp_q.size());
      end
      nvec++;
      if (addr_a !== 6'(exp_addr) || busy_a !== 1'b0 || viol_a !== 0) begin
        nerr++;
        $display("FAIL random_end[%0d]: addr=%0d busy=%b violations=%0d, required %0d 0 0", it, addr_a, busy_a, viol_a, exp_addr);
      end
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_delay();
    logic [9:0] w[$] = '{10'h011, 10'h029, 10'h0FF};
    bit ok;
    int d, gap, tail;
    force_low = 1'b0; rand_ready = 1'b0;
    load_rom_a(w); model_a(); clear_rec();
    pulse_start_a();
    wait_done_a(500, ok);
    d = seq_diff(hs_a, exp_q);
    nvec++;
    if (!ok || d !== -1) begin nerr++; $display("FAIL delay_seq: done=%b handshakes=%0d diff=%0d, required 1 2 -1", ok, hs_a.size(), d); end
    gap  = (hs_cyc_a.size() == 2) ? hs_cyc_a[1] - hs_cyc_a[0] : 0;
    tail = (hs_cyc_a.size() == 2) ? done_cyc_a - hs_cyc_a[1] : 0;
`ifdef ILI9341_INIT_DELAY_EN
    nvec++;
    if (gap < int'(DLY) + 1) begin nerr++; $display("FAIL delay_gap: handshake spacing %0d, required >= %0d", gap, DLY + 1); end
    nvec++;
    if (tail < int'(DLY) + 1) begin nerr++; $display("FAIL delay_tail: done %0d cycles after last byte, required >= %0d", tail, DLY + 1); end
`else
    nvec++;
    if (gap < 1 || gap > 4) begin nerr++; $display("FAIL nodelay_gap: handshake spacing %0d, required 1..4", gap); end
    nvec++;
    if (tail > 4) begin nerr++; $display("FAIL nodelay_tail: done %0d cycles after last byte, required <= 4", tail); end
`endif
  endtask

  task automatic test_wrap();
    int n = 0, d;
    force_low = 1'b0; rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] e;
      e = 10'($urandom);
      if (e[8] == 1'b0 && e[7:0] == 8'hFF) e[7:0] = 8'h00;
      rom_b[i] = e;
    end
    model_b(); clear_rec();
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    b_left0 = 1'b0; b_wrapped = 1'b0;
    while (!done_b && n < 500) begin @(negedge clk); n++; end
    d = seq_diff(hs_b, exp_q);
    nvec++;
    if (!done_b || d !== -1) begin nerr++; $display("FAIL wrap_seq: done=%b handshakes=%0d diff=%0d, required 1 4 -1", done_b, hs_b.size(), d); end
    nvec++;
    if (addr_b !== 2'd3 || b_wrapped !== 1'b0 || busy_b !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_addr: addr=%0d wrapped=%b busy=%b, required 3 0 0", addr_b, b_wrapped, busy_b);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] w[$] = '{10'h036, 10'h148, 10'h0FF};
    int n = 0;
    force_low = 1'b1; rand_ready = 1'b0;
    load_rom_a(w); clear_rec();
    pulse_start_a();
    while (!valid_a && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({valid_a, busy_a, addr_a} !== 8'd0) begin
      nerr++;
      $display("FAIL reset_mid: valid=%b busy=%b addr=%0d, required 0 0 0", valid_a, busy_a, addr_a);
    end
    @(negedge clk) rst_n = 1'b1;
    force_low = 1'b0;
    repeat (30) @(negedge clk);
    nvec++;
    if (hs_a.size() !== 0 || {valid_a, busy_a, done_a} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_noresume: handshakes=%0d valid=%b busy=%b done=%b, required 0 0 0 0", hs_a.size(), valid_a, busy_a, done_a);
    end
  endtask

  task automatic test_start_busy();
    logic [9:0] w[$];
    bit ok;
    int d;
    for (int i = 0; i < 6; i++) w.push_back({1'b0, 1'($urandom), 8'($urandom % 255)});
    w.push_back(10'h0FF);
    force_low = 1'b0; rand_ready = 1'b1;
    load_rom_a(w); model_a(); clear_rec();
    pulse_start_a();
    repeat (3) @(negedge clk);
    nvec++;
    if (busy_a !== 1'b1) begin nerr++; $display("FAIL busy_high: busy=%b required 1", busy_a); end
    pulse_start_a();
    repeat (4) @(negedge clk);
    pulse_start_a();
    wait_done_a(3000, ok);
    d = seq_diff(hs_a, exp_q);
    nvec++;
    if (!ok || d !== -1 || addr_a !== 6'(exp_addr)) begin
      nerr++;
      $display("FAIL start_busy: done=%b handshakes=%0d diff=%0d addr=%0d, required 1 %0d -1 %0d", ok, hs_a.size(), d, addr_a, exp_q.size(), exp_addr);
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d;
    model_a(); clear_rec();
    pulse_start_a();
    nvec++;
    if ({done_a, busy_a} !== 2'b01) begin nerr++; $display("FAIL restart_flags: done=%b busy=%b, required 0 1", done_a, busy_a); end
    wait_done_a(3000, ok);
    d = seq_diff(hs_a, exp_q);
    nvec++;
    if (!ok || d !== -1) begin nerr++; $display("FAIL restart_seq: done=%b handshakes=%0d diff=%0d, required 1 %0d -1", ok, hs_a.size(), d, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random(8);
    test_delay();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
